// File: rtl/rf_wr_arbiter_if.sv
// rf_wr_arbiter_if
//   Bundles the writeback request bus and the register-file write bus that the
//   rf_wr_arbiter sits between.
//   Request side : req_valid[NREQ], req_rd[NREQ*AW], req_data[NREQ*DW], req_ready[NREQ]
//                  (requester i uses slice [i*AW +: AW] / [i*DW +: DW]).
//   Regfile side : rf_wr, rf_en, rf_rd[AW], rf_data[DW], rf_wr_success.
//   Modports     : slave  - the arbiter (consumes requests, drives the regfile)
//                  master - the environment (requesters plus regfile)
interface rf_wr_arbiter_if #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned DW   = 16,
  parameter int unsigned AW   = 3
) ();

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_rd;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;

  logic               rf_wr;
  logic               rf_en;
  logic [AW-1:0]      rf_rd;
  logic [DW-1:0]      rf_data;
  logic               rf_wr_success;

  modport slave (
    input  req_valid, req_rd, req_data, rf_wr_success,
    output req_ready, rf_wr, rf_en, rf_rd, rf_data
  );

  modport master (
    output req_valid, req_rd, req_data, rf_wr_success,
    input  req_ready, rf_wr, rf_en, rf_rd, rf_data
  );

endinterface

// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter
//   Shares the single register-file write port between NREQ writeback requesters
//   (ALU result, load data, link register). Round-robin grant, one write in flight,
//   each write confirmed by the regfile's rf_wr_success pulse or abandoned after
//   ACK_TIMEOUT cycles in ACK (which sets the sticky timeout_err).
//   Sequence per write: IDLE (grant, 0-cycle latency) -> WRITE (strobe) -> ACK.
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous reset, active low
//   bus          rf_wr_arbiter_if.slave: request bus and regfile write bus
//   flush        abandons tracking of the in-flight write while in ACK
//   busy         FSM not in IDLE
//   timeout_err  sticky: some write was never acknowledged (cleared by reset only)
//   fwd_valid    in-flight write visible for forwarding
//   fwd_rd       forwarded destination index
//   fwd_data     forwarded data
//
// Configuration
//   RF_WR_FORWARD_EN  when defined, fwd_* expose the held write during WRITE and ACK;
//                     otherwise fwd_* are tied to zero.
module rf_wr_arbiter #(
  parameter int unsigned NREQ        = 3,
  parameter int unsigned DW          = 16,
  parameter int unsigned AW          = 3,
  parameter int unsigned ACK_TIMEOUT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rf_wr_arbiter_if.slave       bus,
  input  logic                 flush,
  output logic                 busy,
  output logic                 timeout_err,
  output logic                 fwd_valid,
  output logic [AW-1:0]        fwd_rd,
  output logic [DW-1:0]        fwd_data
);

  localparam int unsigned PW = $clog2(NREQ);
  localparam int unsigned TW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StAck
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]   grant_q, grant_d;
  logic [AW-1:0]   hold_rd_q, hold_rd_d;
  logic [DW-1:0]   hold_data_q, hold_data_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            timeout_err_q, timeout_err_d;

  logic            grant_vld;
  logic [PW-1:0]   grant_idx;
  logic [NREQ-1:0] grant_oh;
  logic [AW-1:0]   sel_rd;
  logic [DW-1:0]   sel_data;
  logic [NREQ-1:0] req_ready_c;
  logic [PW-1:0]   next_ptr;

  // First valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    logic [PW:0] sum;
    grant_vld = 1'b0;
    grant_idx = '0;
    sum       = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) begin
        sum = sum - (PW+1)'(NREQ);
      end
      if (!grant_vld && bus.req_valid[sum[PW-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = sum[PW-1:0];
      end
    end
  end

  // Decode the winner into a one-hot ready and mux out its destination and data.
  always_comb begin
    grant_oh = '0;
    sel_rd   = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (PW'(i) == grant_idx) begin
        grant_oh[i] = grant_vld;
        sel_rd      = bus.req_rd[i*AW +: AW];
        sel_data    = bus.req_data[i*DW +: DW];
      end
    end
  end

  assign next_ptr = (grant_q == PW'(NREQ - 1)) ? '0 : grant_q + PW'(1);

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_d       = grant_q;
    hold_rd_d     = hold_rd_q;
    hold_data_d   = hold_data_q;
    timer_d       = timer_q;
    timeout_err_d = timeout_err_q;
    req_ready_c   = '0;
    bus.rf_wr     = 1'b0;
    bus.rf_en     = 1'b0;
    bus.rf_rd     = '0;
    bus.rf_data   = '0;

    unique case (state_q)
      StIdle: begin
        // flush and rf_wr_success have no meaning here.
        if (grant_vld) begin
          req_ready_c = grant_oh;
          grant_d     = grant_idx;
          hold_rd_d   = sel_rd;
          hold_data_d = sel_data;
          state_d     = StWrite;
        end
      end
      StWrite: begin
        // Not cancellable: the strobe goes out even if flush is high.
        bus.rf_wr   = 1'b1;
        bus.rf_en   = 1'b1;
        bus.rf_rd   = hold_rd_q;
        bus.rf_data = hold_data_q;
        timer_d     = '0;
        state_d     = StAck;
      end
      StAck: begin
        bus.rf_en   = 1'b1;
        bus.rf_rd   = hold_rd_q;
        bus.rf_data = hold_data_q;
        timer_d     = timer_q + TW'(1);
        // Success beats a coincident timeout; flush also beats the timeout.
        if (bus.rf_wr_success || flush) begin
          state_d  = StIdle;
          rr_ptr_d = next_ptr;
        end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
          state_d       = StIdle;
          rr_ptr_d      = next_ptr;
          timeout_err_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      rr_ptr_q      <= '0;
      grant_q       <= '0;
      hold_rd_q     <= '0;
      hold_data_q   <= '0;
      timer_q       <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_q       <= grant_d;
      hold_rd_q     <= hold_rd_d;
      hold_data_q   <= hold_data_d;
      timer_q       <= timer_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Ready is combinational from req_valid; mask it so every output is 0 in reset.
  assign bus.req_ready = req_ready_c & {NREQ{rst_n}};
  assign busy          = (state_q != StIdle);
  assign timeout_err   = timeout_err_q;

`ifdef RF_WR_FORWARD_EN
  assign fwd_valid = (state_q == StWrite) || (state_q == StAck);
  assign fwd_rd    = fwd_valid ? hold_rd_q : '0;
  assign fwd_data  = fwd_valid ? hold_data_q : '0;
`else
  assign fwd_valid = 1'b0;
  assign fwd_rd    = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_rf_wr_arbiter.sv
module tb_rf_wr_arbiter;

  localparam int unsigned NREQ        = 3;
  localparam int unsigned DW          = 16;
  localparam int unsigned AW          = 3;
  localparam int unsigned ACK_TIMEOUT = 4;
`ifdef RF_WR_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          busy;
  logic          timeout_err;
  logic          fwd_valid;
  logic [AW-1:0] fwd_rd;
  logic [DW-1:0] fwd_data;

  rf_wr_arbiter_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) bus ();

  rf_wr_arbiter #(
    .NREQ        (NREQ),
    .DW          (DW),
    .AW          (AW),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .flush       (flush),
    .busy        (busy),
    .timeout_err (timeout_err),
    .fwd_valid   (fwd_valid),
    .fwd_rd      (fwd_rd),
    .fwd_data    (fwd_data)
  );

  always #5 clk = ~clk;

  // Reference model: pending requests per requester, pointer, sticky error.
  bit            pend_v    [NREQ];
  logic [AW-1:0] pend_rd   [NREQ];
  logic [DW-1:0] pend_data [NREQ];
  int            ptr;
  bit            exp_err;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]           = pend_v[i];
      bus.req_rd[i*AW +: AW]     = pend_rd[i];
      bus.req_data[i*DW +: DW]   = pend_data[i];
    end
  endtask

  function automatic int pick_grant();
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (ptr + k) % NREQ;
      if (pend_v[i]) return i;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [AW-1:0] rd, input logic [DW-1:0] d);
    pend_v[i]    = 1'b1;
    pend_rd[i]   = rd;
    pend_data[i] = d;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".busy"},   32'(busy), 32'd0);
    check_eq({tag, ".rf_wr"},  32'(bus.rf_wr), 32'd0);
    check_eq({tag, ".rf_en"},  32'(bus.rf_en), 32'd0);
    check_eq({tag, ".rf_rd"},  32'(bus.rf_rd), 32'd0);
    check_eq({tag, ".rf_dat"}, 32'(bus.rf_data), 32'd0);
    check_eq({tag, ".ready"},  32'(bus.req_ready), 32'd0);
    check_eq({tag, ".err"},    32'(timeout_err), 32'd0);
    check_eq({tag, ".fwd_v"},  32'(fwd_valid), 32'd0);
    check_eq({tag, ".fwd_rd"}, 32'(fwd_rd), 32'd0);
    check_eq({tag, ".fwd_d"},  32'(fwd_data), 32'd0);
  endtask

  task automatic check_active(input string tag, input bit wr, input logic [AW-1:0] rd,
                              input logic [DW-1:0] d);
    check_eq({tag, ".busy"},   32'(busy), 32'd1);
    check_eq({tag, ".rf_wr"},  32'(bus.rf_wr), 32'(wr));
    check_eq({tag, ".rf_en"},  32'(bus.rf_en), 32'd1);
    check_eq({tag, ".rf_rd"},  32'(bus.rf_rd), 32'(rd));
    check_eq({tag, ".rf_dat"}, 32'(bus.rf_data), 32'(d));
    check_eq({tag, ".ready"},  32'(bus.req_ready), 32'd0);
    check_eq({tag, ".err"},    32'(timeout_err), 32'(exp_err));
    check_eq({tag, ".fwd_v"},  32'(fwd_valid), 32'(FWD));
    if (FWD) begin
      check_eq({tag, ".fwd_rd"}, 32'(fwd_rd), 32'(rd));
      check_eq({tag, ".fwd_d"},  32'(fwd_data), 32'(d));
    end else begin
      check_eq({tag, ".fwd_rd"}, 32'(fwd_rd), 32'd0);
      check_eq({tag, ".fwd_d"},  32'(fwd_data), 32'd0);
    end
  endtask

  // One arbitration slot starting at an IDLE cycle. resp_d: ACK cycle index carrying
  // rf_wr_success (>= ACK_TIMEOUT means never); flush_at / rst_at: ACK cycle index
  // of flush / reset (-1 none); noise: random flush/success outside ACK.
  task automatic run_txn(input string tag, input int resp_d, input int flush_at,
                         input int rst_at, input bit noise);
    int            g;
    bit            done;
    logic [AW-1:0] e_rd;
    logic [DW-1:0] e_data;
    logic [31:0]   exp_rdy;
    g = pick_grant();
    drive_reqs();
    flush             = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    bus.rf_wr_success = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    exp_rdy = (g < 0) ? 32'd0 : (32'd1 << g);
    @(negedge clk);
    check_eq({tag, ".idle_busy"},  32'(busy), 32'd0);
    check_eq({tag, ".idle_rf_en"}, 32'(bus.rf_en), 32'd0);
    check_eq({tag, ".idle_rf_wr"}, 32'(bus.rf_wr), 32'd0);
    check_eq({tag, ".idle_rd"},    32'(bus.rf_rd), 32'd0);
    check_eq({tag, ".idle_data"},  32'(bus.rf_data), 32'd0);
    check_eq({tag, ".idle_err"},   32'(timeout_err), 32'(exp_err));
    check_eq({tag, ".idle_fwd"},   32'(fwd_valid), 32'd0);
    check_eq({tag, ".grant"},      32'(bus.req_ready), exp_rdy);
    @(posedge clk); #1;
    if (g < 0) begin
      flush = 1'b0;
      bus.rf_wr_success = 1'b0;
      return;
    end
    e_rd      = pend_rd[g];
    e_data    = pend_data[g];
    pend_v[g] = 1'b0;
    drive_reqs();
    flush             = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    bus.rf_wr_success = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    @(negedge clk);
    check_active({tag, ".write"}, 1'b1, e_rd, e_data);
    @(posedge clk); #1;
    for (int k = 0; k < ACK_TIMEOUT; k++) begin
      flush             = (k == flush_at);
      bus.rf_wr_success = (k == resp_d);
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        check_all_zero({tag, ".rst"});
        flush             = 1'b0;
        bus.rf_wr_success = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        ptr     = 0;
        exp_err = 1'b0;
        return;
      end
      @(negedge clk);
      check_active({tag, ".ack"}, 1'b0, e_rd, e_data);
      done = 1'b0;
      if (k == resp_d || k == flush_at) begin
        done = 1'b1;
      end else if (k == ACK_TIMEOUT - 1) begin
        done    = 1'b1;
        exp_err = 1'b1;
      end
      @(posedge clk); #1;
      if (done) break;
    end
    flush             = 1'b0;
    bus.rf_wr_success = 1'b0;
    ptr               = (g + 1) % NREQ;
  endtask

  task automatic arm_all();
    for (int i = 0; i < NREQ; i++) begin
      if (!pend_v[i]) set_req(i, AW'($urandom), DW'($urandom));
    end
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      pend_v[i]    = 1'b0;
      pend_rd[i]   = '0;
      pend_data[i] = '0;
    end
    ptr     = 0;
    exp_err = 1'b0;
    bus.rf_wr_success = 1'b0;
    drive_reqs();

    // Reset state.
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single write with success on the first ACK cycle.
    set_req(0, 3'd3, 16'hBEEF);
    run_txn("single", 0, -1, -1, 1'b0);
    run_txn("single_after", 0, -1, -1, 1'b0);

    // Round-robin with every requester continuously valid: grants 1,2,0,1 from ptr 1.
    for (int n = 0; n < 4; n++) begin
      arm_all();
      run_txn($sformatf("rr%0d", n), 0, -1, -1, 1'b0);
    end

    // Flush on the first ACK cycle: back to IDLE, no error.
    set_req(1, 3'd5, 16'h1234);
    run_txn("flush", 99, 0, -1, 1'b0);

    // Success coincident with the last ACK cycle: no error.
    set_req(2, 3'd6, 16'h5A5A);
    run_txn("late_ok", ACK_TIMEOUT - 1, -1, -1, 1'b0);

    // Timeout: never acknowledged; error is sticky and later writes still serviced.
    set_req(0, 3'd1, 16'hDEAD);
    run_txn("timeout", 99, -1, -1, 1'b0);
    set_req(1, 3'd2, 16'hCAFE);
    run_txn("post_to", 1, -1, -1, 1'b0);

    // Forwarding visibility for a link write.
    set_req(2, 3'd7, 16'h0042);
    run_txn("fwd", 2, -1, -1, 1'b0);

    // Reset in the middle of ACK drops the write and clears the error.
    set_req(0, 3'd4, 16'h7777);
    run_txn("rst_mid", 99, -1, 1, 1'b0);
    run_txn("rst_idle", 0, -1, -1, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      int rd_d, fl, rs;
      for (int i = 0; i < NREQ; i++) begin
        if (!pend_v[i] && $urandom_range(0, 2) == 0) set_req(i, AW'($urandom), DW'($urandom));
      end
      rd_d = $urandom_range(0, ACK_TIMEOUT + 1);
      fl   = ($urandom_range(0, 4) == 0) ? $urandom_range(0, ACK_TIMEOUT - 1) : -1;
      rs   = ($urandom_range(0, 39) == 0) ? $urandom_range(0, ACK_TIMEOUT - 1) : -1;
      run_txn($sformatf("rnd%0d", n), rd_d, fl, rs, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
